// File: rtl/aes_enc_wb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_wb_master_if
// Brief    : Wishbone bus bundle between the AES master and the AES slave.
// Revision : 1.0
// ============================================================================
interface aes_enc_wb_master_if;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface
`default_nettype wire

// File: rtl/aes_enc_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_wb_master
// Brief    : Wishbone master for an AES slave: writes plaintext, polls done,
//            reads ciphertext. Define AES_WB_POLL_TIMEOUT_EN for poll timeout.
// Revision : 1.0
// ============================================================================
module aes_enc_wb_master #(
  parameter int RD_LAG   = 1,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  wire          wb_clk_i,
  input  wire          wb_rst_i,
  input  wire          req_i,
  input  wire  [127:0] plaintext_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [127:0] ciphertext_o,
  aes_enc_wb_master_if.master wb
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_GAP      = 3'd2,
    S_POLL     = 3'd3,
    S_POLL_CAP = 3'd4,
    S_READ     = 3'd5,
    S_READ_CAP = 3'd6,
    S_FINISH   = 3'd7
  } state_t;

  localparam int                 c_GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);
  localparam bit                 c_LAG0     = (RD_LAG == 0);

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_idx, w_idx_nxt;
  logic [c_GAP_W-1:0]   r_gap, w_gap_nxt;
  logic [127:0]         r_pt, w_pt_nxt;
  logic [95:0]          r_buf, w_buf_nxt;
  logic [127:0]         r_ct, w_ct_nxt;
  logic [31:0]          w_pt_word;
  logic                 w_poll_smp;
  logic                 w_rd_smp;

`ifdef AES_WB_POLL_TIMEOUT_EN
  localparam int                  c_POLL_W    = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_MAX - 1);
  logic [c_POLL_W-1:0] r_poll, w_poll_nxt;
  logic                r_err, w_err_nxt;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_gap   <= '0;
      r_pt    <= '0;
      r_buf   <= '0;
      r_ct    <= '0;
`ifdef AES_WB_POLL_TIMEOUT_EN
      r_poll  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_pt    <= w_pt_nxt;
      r_buf   <= w_buf_nxt;
      r_ct    <= w_ct_nxt;
`ifdef AES_WB_POLL_TIMEOUT_EN
      r_poll  <= w_poll_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_pt_nxt    = r_pt;
    w_buf_nxt   = r_buf;
    w_ct_nxt    = r_ct;
    w_poll_smp  = 1'b0;
    w_rd_smp    = 1'b0;
`ifdef AES_WB_POLL_TIMEOUT_EN
    w_poll_nxt  = r_poll;
    w_err_nxt   = r_err;
`endif
    wb.wb_adr_o = 8'h00;
    wb.wb_dat_o = 32'h0;
    wb.wb_sel_o = 4'h0;
    wb.wb_we_o  = 1'b0;
    wb.wb_cyc_o = 1'b0;
    wb.wb_stb_o = 1'b0;

    case (r_idx)
      2'd0:    w_pt_word = r_pt[127:96];
      2'd1:    w_pt_word = r_pt[95:64];
      2'd2:    w_pt_word = r_pt[63:32];
      default: w_pt_word = r_pt[31:0];
    endcase

    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_pt_nxt    = plaintext_i;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_WRITE;
`ifdef AES_WB_POLL_TIMEOUT_EN
          w_poll_nxt  = '0;
          w_err_nxt   = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_stb_o = 1'b1;
        wb.wb_we_o  = 1'b1;
        wb.wb_sel_o = 4'hF;
        wb.wb_adr_o = {4'h0, r_idx, 2'b00};
        wb.wb_dat_o = w_pt_word;
        if (wb.wb_ack_i) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      // Idle time lets the slave's stale done bit from a prior run clear.
      S_GAP: begin
        if (r_gap == c_GAP_LAST) w_state_nxt = S_POLL;
        else                     w_gap_nxt   = r_gap + 1'b1;
      end
      S_POLL: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_stb_o = 1'b1;
        wb.wb_sel_o = 4'hF;
        wb.wb_adr_o = 8'h20;
        if (wb.wb_ack_i) begin
          if (c_LAG0) w_poll_smp  = 1'b1;
          else        w_state_nxt = S_POLL_CAP;
        end
      end
      S_POLL_CAP: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_sel_o = 4'hF;
        wb.wb_adr_o = 8'h20;
        w_poll_smp  = 1'b1;
      end
      S_READ: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_stb_o = 1'b1;
        wb.wb_sel_o = 4'hF;
        wb.wb_adr_o = {4'h1, r_idx, 2'b00};
        if (wb.wb_ack_i) begin
          if (c_LAG0) w_rd_smp    = 1'b1;
          else        w_state_nxt = S_READ_CAP;
        end
      end
      S_READ_CAP: begin
        wb.wb_cyc_o = 1'b1;
        wb.wb_sel_o = 4'hF;
        wb.wb_adr_o = {4'h1, r_idx, 2'b00};
        w_rd_smp    = 1'b1;
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    if (w_poll_smp) begin
      if (wb.wb_dat_i[0]) begin
        w_state_nxt = S_READ;
        w_idx_nxt   = 2'd0;
      end else begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = '0;
`ifdef AES_WB_POLL_TIMEOUT_EN
        w_poll_nxt  = r_poll + 1'b1;
        if (r_poll == c_POLL_LAST) begin
          w_state_nxt = S_FINISH;
          w_err_nxt   = 1'b1;
        end
`endif
      end
    end

    // Words land in a side buffer so a partial read never disturbs ciphertext_o.
    if (w_rd_smp) begin
      case (r_idx)
        2'd0: w_buf_nxt[95:64] = wb.wb_dat_i;
        2'd1: w_buf_nxt[63:32] = wb.wb_dat_i;
        2'd2: w_buf_nxt[31:0]  = wb.wb_dat_i;
        default: begin
          w_ct_nxt    = {r_buf, wb.wb_dat_i};
          w_state_nxt = S_FINISH;
        end
      endcase
      if (r_idx != 2'd3) begin
        w_idx_nxt   = r_idx + 2'd1;
        w_state_nxt = S_READ;
      end
    end
  end

  assign busy_o       = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done_o       = (r_state == S_FINISH);
  assign ciphertext_o = r_ct;
`ifdef AES_WB_POLL_TIMEOUT_EN
  assign err_o        = done_o & r_err;
`else
  assign err_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_enc_wb_master
// Brief    : Directed bench for aes_enc_wb_master with a Wishbone AES slave model.
// Revision : 1.0
// ============================================================================
module tb_aes_enc_wb_master;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         req   = 1'b0;
  logic [127:0] pt    = '0;
  logic         sel_b = 1'b0;

  always #5 clk = ~clk;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [31:0] pt_words [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] ct_words [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

  aes_enc_wb_master_if ifa ();
  aes_enc_wb_master_if ifb ();

  logic         busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [127:0] ct_a, ct_b;

  aes_enc_wb_master #(.RD_LAG(1), .POLL_GAP(4), .POLL_MAX(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req & ~sel_b), .plaintext_i(pt),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .ciphertext_o(ct_a), .wb(ifa)
  );

  aes_enc_wb_master #(.RD_LAG(0), .POLL_GAP(4), .POLL_MAX(8)) dut_lag0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req & sel_b), .plaintext_i(pt),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .ciphertext_o(ct_b), .wb(ifb)
  );

  // Slave model, shared by both masters through a mux.
  int  n_wait     = 0;
  bit  comb_rd    = 1'b0;
  bit  never_done = 1'b0;

  logic        s_cyc, s_stb, s_we, s_ack, s_done;
  logic [7:0]  s_adr;
  logic [31:0] s_wdat, s_rdat, s_rd_comb, s_rd_q;
  int          cyc_n = 0, wcnt = 0, t_wr = 0;
  bit          armed = 1'b0, eng_busy = 1'b0;

  assign s_cyc  = sel_b ? ifb.wb_cyc_o : ifa.wb_cyc_o;
  assign s_stb  = sel_b ? ifb.wb_stb_o : ifa.wb_stb_o;
  assign s_we   = sel_b ? ifb.wb_we_o  : ifa.wb_we_o;
  assign s_adr  = sel_b ? ifb.wb_adr_o : ifa.wb_adr_o;
  assign s_wdat = sel_b ? ifb.wb_dat_o : ifa.wb_dat_o;
  assign s_ack  = s_cyc & s_stb & (wcnt == n_wait);
  assign s_rdat = comb_rd ? s_rd_comb : s_rd_q;
  assign ifa.wb_ack_i = s_ack & ~sel_b;
  assign ifb.wb_ack_i = s_ack & sel_b;
  assign ifa.wb_dat_i = s_rdat;
  assign ifb.wb_dat_i = s_rdat;

  always_comb begin
    s_rd_comb = 32'h0;
    case (s_adr)
      8'h10:   s_rd_comb = ct_words[0];
      8'h14:   s_rd_comb = ct_words[1];
      8'h18:   s_rd_comb = ct_words[2];
      8'h1C:   s_rd_comb = ct_words[3];
      8'h20:   s_rd_comb = {31'h0, s_done};
      default: s_rd_comb = 32'h0;
    endcase
  end

  logic [7:0]  wr_adr [$];
  logic [31:0] wr_dat [$];
  int          wr_t   [$];
  int          n_poll = 0, n_ctrd = 0, n_early = 0, first_poll = -1;
  int          stab_bad = 0, hold_cnt = 0, proto_bad = 0;
  bit          hold_v = 1'b0;
  logic [7:0]  h_adr = '0;
  logic [31:0] h_dat = '0;
  logic        h_we = 1'b0;

  initial s_done = 1'b0;
  initial s_rd_q = 32'h0;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    wcnt  <= (s_cyc && s_stb && !s_ack) ? wcnt + 1 : 0;
    if (s_ack) s_rd_q <= s_rd_comb;
    if (s_ack && s_we && s_adr == 8'h0C) begin
      t_wr <= cyc_n; armed <= 1'b1; eng_busy <= 1'b1; first_poll <= -1;
    end else if (armed) begin
      if (cyc_n == t_wr + 2) s_done <= 1'b0;
      if (cyc_n == t_wr + 20 && !never_done) begin
        s_done <= 1'b1; armed <= 1'b0; eng_busy <= 1'b0;
      end
    end
    if (s_ack && s_we) begin
      wr_adr.push_back(s_adr); wr_dat.push_back(s_wdat); wr_t.push_back(cyc_n);
    end
    if (s_ack && !s_we && s_adr == 8'h20) begin
      n_poll <= n_poll + 1;
      if (first_poll < 0) first_poll <= cyc_n - t_wr;
    end
    if (s_ack && !s_we && s_adr[7:4] == 4'h1) begin
      n_ctrd <= n_ctrd + 1;
      if (eng_busy) n_early <= n_early + 1;
    end
    if (s_cyc && s_stb) begin
      if (hold_v) begin
        hold_cnt <= hold_cnt + 1;
        if (s_adr !== h_adr || s_wdat !== h_dat || s_we !== h_we) stab_bad <= stab_bad + 1;
      end
      hold_v <= !s_ack; h_adr <= s_adr; h_dat <= s_wdat; h_we <= s_we;
    end else begin
      hold_v <= 1'b0;
    end
    if ((ifa.wb_stb_o && !ifa.wb_cyc_o) || (ifb.wb_stb_o && !ifb.wb_cyc_o) ||
        (ifa.wb_cyc_o && ifa.wb_sel_o != 4'hF) || (ifb.wb_cyc_o && ifb.wb_sel_o != 4'hF))
      proto_bad <= proto_bad + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic start_op(input logic [127:0] p);
    @(negedge clk); req = 1'b1; pt = p;
    @(negedge clk); req = 1'b0;
    chk("start_busy", sel_b ? busy_b : busy_a, 1'b1);
  endtask

  task automatic wait_done(input string tag, output int t_done);
    for (int i = 0; i < 3000; i++) begin
      if (sel_b ? done_b : done_a) break;
      @(negedge clk);
    end
    t_done = cyc_n;
    chk(tag, sel_b ? done_b : done_a, 1'b1);
  endtask

  task automatic chk_writes(input string tag, input int base, input bit consec);
    chk({tag, "_nwr"}, wr_adr.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_adr%0d", tag, i), wr_adr[base+i], 8'(4*i));
      chk($sformatf("%s_dat%0d", tag, i), wr_dat[base+i], pt_words[i]);
      if (consec && i > 0) chk($sformatf("%s_t%0d", tag, i), wr_t[base+i] - wr_t[base+i-1], 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b_wr, b_poll, b_early, b_stab, b_hold, b_ctrd, t_done;
  bit hit;

  initial begin
    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy_done_err_a", {busy_a, done_a, err_a}, 3'b000);
    chk("rst_cyc_stb_we_a", {ifa.wb_cyc_o, ifa.wb_stb_o, ifa.wb_we_o}, 3'b000);
    chk("rst_adr_a", ifa.wb_adr_o, 8'h00);
    chk("rst_dat_a", ifa.wb_dat_o, 32'h0);
    chk("rst_sel_a", ifa.wb_sel_o, 4'h0);
    chk("rst_ct_a", ct_a, 128'h0);
    chk("rst_flags_b", {busy_b, done_b, err_b, ifb.wb_cyc_o, ifb.wb_stb_o, ifb.wb_we_o}, 6'h0);
    chk("rst_ct_b", ct_b, 128'h0);
    rst = 1'b1;
    @(negedge clk);

    // Zero-wait slave, RD_LAG=1
    sel_b = 1'b0; comb_rd = 1'b0; n_wait = 0;
    b_wr = wr_adr.size(); b_poll = n_poll; b_early = n_early;
    start_op(PT);
    wait_done("t1_done", t_done);
    chk("t1_ct", ct_a, CT);
    chk("t1_err", err_a, 1'b0);
    chk("t1_busy_in_finish", busy_a, 1'b0);
    chk("t1_latency", t_done - t_wr, 33);
    @(negedge clk);
    chk("t1_done_one_cycle", done_a, 1'b0);
    chk_writes("t1", b_wr, 1'b1);
    chk("t1_first_poll", first_poll, 5);
    chk("t1_polls", n_poll - b_poll, 4);
    chk("t1_early_rd", n_early - b_early, 0);

    // Two wait states per access; done bit still set from the previous run
    n_wait = 2;
    b_wr = wr_adr.size(); b_poll = n_poll; b_early = n_early;
    b_stab = stab_bad; b_hold = hold_cnt;
    start_op(PT);
    wait_done("t2_done", t_done);
    chk("t2_ct", ct_a, CT);
    chk("t2_err", err_a, 1'b0);
    chk_writes("t2", b_wr, 1'b0);
    chk("t2_stable", stab_bad - b_stab, 0);
    chk("t2_stretched", (hold_cnt - b_hold) > 0, 1'b1);
    chk("t2_early_rd", n_early - b_early, 0);
    chk("t2_first_poll", first_poll, 7);
    chk("t2_polls", n_poll - b_poll, 3);

    // Reset during the second ciphertext read
    n_wait = 0;
    start_op(PT);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (ifa.wb_stb_o && ifa.wb_adr_o == 8'h14) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("t3_reached_rd1", hit, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("t3_cyc_stb", {ifa.wb_cyc_o, ifa.wb_stb_o}, 2'b00);
    chk("t3_busy", busy_a, 1'b0);
    chk("t3_ct_cleared", ct_a, 128'h0);
    rst = 1'b1;
    @(negedge clk);
    start_op(PT);
    wait_done("t3_done", t_done);
    chk("t3_ct", ct_a, CT);
    chk("t3_err", err_a, 1'b0);

    // RD_LAG=0 master, extra request during WRITE
    sel_b = 1'b1; comb_rd = 1'b1; n_wait = 0;
    b_wr = wr_adr.size(); b_poll = n_poll;
    start_op(PT);
    req = 1'b1; pt = ~PT;
    @(negedge clk);
    req = 1'b0; pt = PT;
    wait_done("t4_done", t_done);
    chk("t4_ct", ct_b, CT);
    chk("t4_err", err_b, 1'b0);
    chk("t4_latency", t_done - t_wr, 30);
    chk("t4_first_poll", first_poll, 5);
    chk("t4_polls", n_poll - b_poll, 5);
    chk_writes("t4", b_wr, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4_no_queued_req", {busy_b, 32'(wr_adr.size() - b_wr)}, {1'b0, 32'd4});

`ifdef AES_WB_POLL_TIMEOUT_EN
    // Poll timeout with POLL_MAX=8 and a slave that never finishes
    sel_b = 1'b0; comb_rd = 1'b0; n_wait = 0; never_done = 1'b1;
    b_poll = n_poll; b_ctrd = n_ctrd;
    start_op(PT);
    wait_done("t5_done", t_done);
    chk("t5_err", err_a, 1'b1);
    chk("t5_ct_kept", ct_a, CT);
    chk("t5_polls", n_poll - b_poll, 8);
    chk("t5_no_ct_rd", n_ctrd - b_ctrd, 0);
    never_done = 1'b0;
`endif

    @(negedge clk);
    chk("protocol_cyc_stb_sel", proto_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_enc_wb_master.md
AES_ENC_WB_MASTER -- requirements
Module: aes_enc_wb_master

Interface
REQ-001 Parameter RD_LAG, default 1: cycles between the read ack edge and the wb_dat_i capture edge; legal values 0 or 1.
REQ-002 Parameter POLL_GAP, default 4: idle cycles (cyc_o=0) before each done-register poll; minimum 2.
REQ-003 Parameter POLL_MAX, default 1024: poll count limit, used only with the timeout feature.
REQ-004 wb_clk_i  in  1  single clock; everything SHALL be synchronous to its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-low.
REQ-006 req_i  in  1  start request, sampled in IDLE.
REQ-007 plaintext_i  in  128  block to encrypt, sampled with req_i.
REQ-008 busy_o  out  1  operation in progress.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 err_o  out  1  valid with done_o; 1 = poll timeout.
REQ-011 ciphertext_o  out  128  result, bits [127:96] from offset 0x10.
REQ-012 wb_adr_o  out  8  Wishbone address.
REQ-013 wb_dat_o  out  32  Wishbone write data.
REQ-014 wb_dat_i  in  32  Wishbone read data, registered by the slave.
REQ-015 wb_sel_o  out  4  byte select, always 4'hF during a cycle.
REQ-016 wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone write enable, cycle, strobe.
REQ-017 wb_ack_i  in  1  Wishbone acknowledge, may be combinational.

Function
REQ-018 Slave map: 0x00/04/08/0C plaintext words MSB first; 0x10/14/18/1C ciphertext words MSB first; 0x20 done in bit 0.
REQ-019 States: IDLE, WRITE, GAP, POLL, POLL_CAP, READ, READ_CAP, FINISH.
REQ-020 IDLE: req_i=1 latches plaintext_i, sets word index to 0, enters WRITE, and raises busy_o on the next edge.
REQ-021 WRITE: cyc/stb/we=1, adr=0x00+4*idx, dat=plaintext word idx; each ack increments idx; the ack with idx=3 leads to GAP.
REQ-022 Zero-wait slave: four writes occupy four consecutive cycles; on a wait state, adr, dat and we are held until ack.
REQ-023 GAP: cyc/stb=0 for POLL_GAP cycles, then POLL; this covers the slave's stale done bit, which clears 2 cycles after the 0x0C write.
REQ-024 POLL: read 0x20 (we=0); on ack, deassert stb, spend RD_LAG cycles in POLL_CAP, then sample wb_dat_i[0]; 1 leads to READ with idx=0, 0 leads to GAP.
REQ-025 READ/READ_CAP: read 0x10+4*idx; capture RD_LAG cycles after ack into ciphertext word idx; idx=3 capture leads to FINISH.
REQ-026 FINISH: update ciphertext_o from the capture buffer, pulse done_o with err_o=0, drop busy_o, and return to IDLE in one cycle.
REQ-027 ciphertext_o SHALL hold its value between completions; partial reads never alter it.
REQ-028 req_i while busy_o=1 is ignored and not queued.
REQ-029 wb_cyc_o is 0 in IDLE, GAP and FINISH; wb_stb_o is never 1 while wb_cyc_o is 0.

Reset
REQ-030 wb_rst_i=0 at an edge forces IDLE from any state, including mid-transfer, and clears idx and the poll counter.
REQ-031 Reset values: busy_o, done_o, err_o, wb_cyc_o, wb_stb_o and wb_we_o are 0; wb_adr_o, wb_dat_o, wb_sel_o and ciphertext_o are all zeros.

Configuration
REQ-032 With AES_WB_POLL_TIMEOUT_EN defined: a counter increments per POLL; reaching POLL_MAX without done=1 leads to FINISH with done_o=1, err_o=1, and ciphertext_o unchanged.
REQ-033 Without AES_WB_POLL_TIMEOUT_EN: polling continues indefinitely, err_o is tied to 0, and POLL_MAX is unused.

Verification
REQ-034 Zero-wait slave model, slave engine done 20 cycles after the 0x0C write, plaintext 00112233445566778899aabbccddeeff -> writes 00112233, 44556677, 8899aabb and ccddeeff to 0x00-0x0C in 4 consecutive cycles; ciphertext_o=69c4e0d86a7b0430d8cdb78070b4c55a; done_o high exactly 1 cycle; err_o=0.
REQ-035 Slave with 2 wait states per access -> same result, and adr and dat are stable throughout every stretched cycle.
REQ-036 Done bit left at 1 by a prior operation -> no ciphertext read before the new done; first poll occurs at least 2 cycles after the 0x0C ack.
REQ-037 Reset asserted during the second ciphertext read -> next edge gives IDLE, cyc/stb=0, and ciphertext_o=0; a new req_i completes normally.
REQ-038 AES_WB_POLL_TIMEOUT_EN defined, POLL_MAX=8, done never set -> exactly 8 reads of 0x20, then done_o=1 with err_o=1, ciphertext_o unchanged.
REQ-039 req_i pulsed during WRITE, then RD_LAG=0 regression -> extra request ignored; capture occurs on the ack edge with the same result.
